t08_wb_arbiter: RTL and testbench
=================================

Name: t08_wb_arbiter

Overview:
- Shares the single Wishbone master port of the team_08 chip between two on-chip requesters.
  - Requester 0: touchscreen/I2C event handler.
  - Requester 1: display/SPI draw engine.
- Round-robin grant, one classic single-beat Wishbone transaction at a time.
- ACK timeout so a dead slave cannot hang either requester.
- Sits inside t08_top, directly in front of the wb_* ports.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUS without ACK before abort; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock
- nRst  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 wants a transaction; held high until req0_done
- req0_we  in  1  1 = write, 0 = read
- req0_adr  in  32  byte address
- req0_wdat  in  32  write data
- req0_sel  in  4  byte lane selects
- req0_done  out  1  one-cycle completion pulse
- req0_err  out  1  valid with req0_done: 1 = timed out
- req1_valid / req1_we / req1_adr / req1_wdat / req1_sel / req1_done / req1_err: same widths and meanings for requester 1
- rdata  out  32  read data, valid in the cycle either done is high
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte selects
- wb_we_o  out  1  Wishbone write enable
- wb_stb_o  out  1  Wishbone strobe
- wb_cyc_o  out  1  Wishbone cycle
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- All state is registered, and all outputs are registered.

Reset (nRst low at a clk edge):
- state = IDLE; every output = 0, including rdata and all wb_*.
- last_grant = 1, so requester 0 wins the first tie.
- Reset takes effect mid-transaction: the bus drops CYC/STB at the next edge and no done pulse is produced.

State machine (IDLE, BUS, RESP):
- IDLE:
  - If any valid is high, pick the winner:
    - only one valid: that requester wins;
    - both valid: the requester != last_grant wins.
  - Latch the winner's adr/wdat/sel/we onto wb_*, set cyc = stb = 1, clear the counter, set last_grant = winner, go to BUS.
  - Otherwise stay, with wb_* all 0.
- BUS:
  - wb_* held stable, counter increments each cycle.
  - If wb_ack_i: capture rdata = wb_dat_i for reads, 0 for writes; err = 0; go to RESP.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: rdata = 0, err = 1, go to RESP.
  - ACK wins over timeout in the same cycle.
- RESP:
  - cyc, stb, we, adr, dat, sel are all 0.
  - granted reqN_done = 1 for exactly this cycle; reqN_err as captured.
  - Unconditionally return to IDLE.
  - rdata holds its value until the next capture.

Timing and requester rules:
- Latency: valid sampled in cycle t, CYC/STB high from t+1. ACK seen in cycle k gives done in k+1. The earliest next grant is k+2.
- Requester contract: fields stable while valid is high. Valid is dropped at the edge ending the done cycle, or kept high to issue a back-to-back request, which re-arbitrates normally.
- wb_ack_i outside BUS is ignored.
- Valid from the non-granted requester during BUS/RESP waits; it is never lost.
- Fairness: under continuous contention grants strictly alternate 0,1,0,1.
- A requester dropping valid while granted does not abort the bus cycle, and its done still pulses.

Test Plan:
- Single read: reset, req0_valid with adr=0x3000_0010, we=0; slave ACKs in the 3rd BUS cycle with dat_i=0xDEAD_BEEF. Required: cyc/stb high for 3 cycles, then req0_done=1, err=0, rdata=0xDEAD_BEEF one cycle after the ACK.
- Write: req1 we=1, adr=0x3000_0020, wdat=0x1234_5678, sel=0xF; ACK after 1 cycle. Required: wb_dat_o=0x1234_5678, wb_we_o=1 during BUS; req1_done pulse; rdata=0.
- Contention: both valid continuously from reset for 4 transactions, ACK after 1 cycle each. Required: grant order 0,1,0,1; a done pulse every 3 cycles; no cycle has both done high.
- Timeout: TIMEOUT_CYCLES=4, no ACK. Required: cyc high for exactly 4 cycles, then req0_done=1, req0_err=1, rdata=0; the next request proceeds normally.
- ACK/timeout collision: ACK arrives in the 4th BUS cycle with TIMEOUT_CYCLES=4. Required: err=0 and rdata=wb_dat_i.
- Reset mid-BUS: nRst low while cyc=1. Required: next cycle all wb_* and done=0; after release, requester 0 wins a tie.

Source files
------------

// File: rtl/t08_wb_arbiter.sv
// t08_wb_arbiter: shares the chip's single Wishbone master port between two
// requesters (0: touchscreen/I2C event handler, 1: display/SPI draw engine).
// Round-robin grant, one classic single-beat transaction at a time, with an
// ACK timeout so a dead slave cannot hang a requester.
//
// Ports:
//   clk, nRst            clock, synchronous active-low reset
//   reqN_valid/we/adr/wdat/sel  request from requester N (held until done)
//   reqN_done, reqN_err  one-cycle completion pulse, timeout flag with done
//   rdata                read data, valid while either done is high
//   wb_*_o, wb_dat_i, wb_ack_i  Wishbone master port
module t08_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_adr,
  input  logic [31:0] req0_wdat,
  input  logic [3:0]  req0_sel,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_adr,
  input  logic [31:0] req1_wdat,
  input  logic [3:0]  req1_sel,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Last BUS cycle count before abort; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             winner;

  logic        done0_nxt, err0_nxt, done1_nxt, err1_nxt;
  logic [31:0] rdata_nxt, adr_nxt, dat_nxt;
  logic [3:0]  sel_nxt;
  logic        we_nxt, stb_nxt, cyc_nxt;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      req0_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_done  <= 1'b0;
      req1_err   <= 1'b0;
      rdata      <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      req0_done  <= done0_nxt;
      req0_err   <= err0_nxt;
      req1_done  <= done1_nxt;
      req1_err   <= err1_nxt;
      rdata      <= rdata_nxt;
      wb_adr_o   <= adr_nxt;
      wb_dat_o   <= dat_nxt;
      wb_sel_o   <= sel_nxt;
      wb_we_o    <= we_nxt;
      wb_stb_o   <= stb_nxt;
      wb_cyc_o   <= cyc_nxt;
    end
  end

  // Tie goes to the requester that was not granted last.
  assign winner = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  // Next state and next output values.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    done0_nxt      = 1'b0;
    err0_nxt       = 1'b0;
    done1_nxt      = 1'b0;
    err1_nxt       = 1'b0;
    rdata_nxt      = rdata;
    adr_nxt        = wb_adr_o;
    dat_nxt        = wb_dat_o;
    sel_nxt        = wb_sel_o;
    we_nxt         = wb_we_o;
    stb_nxt        = wb_stb_o;
    cyc_nxt        = wb_cyc_o;

    unique case (state)
      IDLE: begin
        adr_nxt = '0;
        dat_nxt = '0;
        sel_nxt = '0;
        we_nxt  = 1'b0;
        stb_nxt = 1'b0;
        cyc_nxt = 1'b0;
        if (req0_valid || req1_valid) begin
          adr_nxt        = winner ? req1_adr  : req0_adr;
          dat_nxt        = winner ? req1_wdat : req0_wdat;
          sel_nxt        = winner ? req1_sel  : req0_sel;
          we_nxt         = winner ? req1_we   : req0_we;
          stb_nxt        = 1'b1;
          cyc_nxt        = 1'b1;
          cnt_nxt        = '0;
          last_grant_nxt = winner;
          state_nxt      = BUS;
        end
      end
      BUS: begin
        cnt_nxt = cnt + CNT_W'(1);
        // ACK has priority over a timeout in the same cycle.
        if (wb_ack_i || (TIMEOUT_CYCLES != 0 && cnt == TO_LAST)) begin
          rdata_nxt = (wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
          done0_nxt = ~last_grant;
          done1_nxt = last_grant;
          err0_nxt  = ~last_grant & ~wb_ack_i;
          err1_nxt  = last_grant & ~wb_ack_i;
          adr_nxt   = '0;
          dat_nxt   = '0;
          sel_nxt   = '0;
          we_nxt    = 1'b0;
          stb_nxt   = 1'b0;
          cyc_nxt   = 1'b0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_t08_wb_arbiter.sv
// Directed bench for t08_wb_arbiter (built with TIMEOUT_CYCLES = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_t08_wb_arbiter;

  logic        clk = 1'b0;
  logic        nRst;
  logic        req0_valid, req0_we, req0_done, req0_err;
  logic [31:0] req0_adr, req0_wdat;
  logic [3:0]  req0_sel;
  logic        req1_valid, req1_we, req1_done, req1_err;
  logic [31:0] req1_adr, req1_wdat;
  logic [3:0]  req1_sel;
  logic [31:0] rdata, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  int vectors = 0;
  int miscompares = 0;

  t08_wb_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .nRst(nRst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_adr(req0_adr),
    .req0_wdat(req0_wdat), .req0_sel(req0_sel), .req0_done(req0_done),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_adr(req1_adr),
    .req1_wdat(req1_wdat), .req1_sel(req1_sel), .req1_done(req1_done),
    .req1_err(req1_err),
    .rdata(rdata), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " cyc"}, 32'(wb_cyc_o), 32'd0);
    chk({tag, " stb"}, 32'(wb_stb_o), 32'd0);
    chk({tag, " done0"}, 32'(req0_done), 32'd0);
    chk({tag, " done1"}, 32'(req1_done), 32'd0);
  endtask

  initial begin
    nRst = 1'b0;
    req0_valid = 0; req0_we = 0; req0_adr = '0; req0_wdat = '0; req0_sel = '0;
    req1_valid = 0; req1_we = 0; req1_adr = '0; req1_wdat = '0; req1_sel = '0;
    wb_dat_i = '0; wb_ack_i = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk_idle("rst");
    chk("rst rdata", rdata, 32'd0);
    chk("rst adr", wb_adr_o, 32'd0);
    chk("rst we", 32'(wb_we_o), 32'd0);
    nRst = 1'b1;
    @(negedge clk);

    // Single read by requester 0, ACK in third BUS cycle
    req0_valid = 1; req0_we = 0; req0_adr = 32'h3000_0010; req0_sel = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("rd cyc", 32'(wb_cyc_o), 32'd1);
      chk("rd stb", 32'(wb_stb_o), 32'd1);
      chk("rd adr", wb_adr_o, 32'h3000_0010);
      chk("rd done0 early", 32'(req0_done), 32'd0);
      if (i == 3) begin wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF; end
    end
    @(negedge clk);
    wb_ack_i = 0; wb_dat_i = '0;
    chk("rd cyc off", 32'(wb_cyc_o), 32'd0);
    chk("rd done0", 32'(req0_done), 32'd1);
    chk("rd err0", 32'(req0_err), 32'd0);
    chk("rd done1", 32'(req1_done), 32'd0);
    chk("rd rdata", rdata, 32'hDEAD_BEEF);
    req0_valid = 0;
    @(negedge clk);
    chk_idle("rd after");
    chk("rd rdata hold", rdata, 32'hDEAD_BEEF);

    // Stray ACK in IDLE is ignored
    wb_ack_i = 1; wb_dat_i = 32'h1111_1111;
    @(negedge clk);
    wb_ack_i = 0; wb_dat_i = '0;
    @(negedge clk);
    chk_idle("stray ack");
    chk("stray rdata", rdata, 32'hDEAD_BEEF);

    // Write by requester 1, ACK in first BUS cycle
    req1_valid = 1; req1_we = 1; req1_adr = 32'h3000_0020;
    req1_wdat = 32'h1234_5678; req1_sel = 4'hF;
    @(negedge clk);
    chk("wr cyc", 32'(wb_cyc_o), 32'd1);
    chk("wr we", 32'(wb_we_o), 32'd1);
    chk("wr dat", wb_dat_o, 32'h1234_5678);
    chk("wr adr", wb_adr_o, 32'h3000_0020);
    chk("wr sel", 32'(wb_sel_o), 32'hF);
    wb_ack_i = 1; wb_dat_i = 32'h9999_9999;
    @(negedge clk);
    wb_ack_i = 0; wb_dat_i = '0;
    chk("wr done1", 32'(req1_done), 32'd1);
    chk("wr err1", 32'(req1_err), 32'd0);
    chk("wr done0", 32'(req0_done), 32'd0);
    chk("wr rdata", rdata, 32'd0);
    chk("wr we off", 32'(wb_we_o), 32'd0);
    req1_valid = 0; req1_we = 0;
    @(negedge clk);
    chk_idle("wr after");

    // Contention from reset: grants alternate 0,1,0,1, one done every 3 cycles
    nRst = 0;
    @(negedge clk);
    nRst = 1;
    req0_valid = 1; req0_we = 0; req0_adr = 32'h3000_0100; req0_sel = 4'h3;
    req1_valid = 1; req1_we = 0; req1_adr = 32'h3000_0200; req1_sel = 4'hC;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("ct cyc", 32'(wb_cyc_o), 32'd1);
      chk("ct adr", wb_adr_o, (t % 2 == 0) ? 32'h3000_0100 : 32'h3000_0200);
      chk("ct sel", 32'(wb_sel_o), (t % 2 == 0) ? 32'h3 : 32'hC);
      wb_ack_i = 1; wb_dat_i = 32'hA000_0000 + 32'(t);
      @(negedge clk);
      wb_ack_i = 0; wb_dat_i = '0;
      chk("ct done0", 32'(req0_done), (t % 2 == 0) ? 32'd1 : 32'd0);
      chk("ct done1", 32'(req1_done), (t % 2 == 0) ? 32'd0 : 32'd1);
      chk("ct rdata", rdata, 32'hA000_0000 + 32'(t));
      @(negedge clk);
      chk_idle("ct gap");
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk_idle("ct after");

    // Timeout: no ACK, abort after 4 BUS cycles
    req0_valid = 1; req0_we = 0; req0_adr = 32'h3000_0300; req0_sel = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("to cyc", 32'(wb_cyc_o), 32'd1);
    end
    @(negedge clk);
    chk("to cyc off", 32'(wb_cyc_o), 32'd0);
    chk("to done0", 32'(req0_done), 32'd1);
    chk("to err0", 32'(req0_err), 32'd1);
    chk("to err1", 32'(req1_err), 32'd0);
    chk("to rdata", rdata, 32'd0);
    req0_valid = 0;
    @(negedge clk);
    chk_idle("to after");
    chk("to err0 clr", 32'(req0_err), 32'd0);

    // Normal request after the timeout
    req1_valid = 1; req1_we = 0; req1_adr = 32'h3000_0400; req1_sel = 4'hF;
    @(negedge clk);
    chk("post cyc", 32'(wb_cyc_o), 32'd1);
    wb_ack_i = 1; wb_dat_i = 32'h5555_AAAA;
    @(negedge clk);
    wb_ack_i = 0; wb_dat_i = '0;
    chk("post done1", 32'(req1_done), 32'd1);
    chk("post err1", 32'(req1_err), 32'd0);
    chk("post rdata", rdata, 32'h5555_AAAA);
    req1_valid = 0;
    @(negedge clk);

    // ACK in the 4th BUS cycle wins over timeout
    req0_valid = 1; req0_we = 0; req0_adr = 32'h3000_0500;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("col cyc", 32'(wb_cyc_o), 32'd1);
      if (i == 4) begin wb_ack_i = 1; wb_dat_i = 32'hCAFE_F00D; end
    end
    @(negedge clk);
    wb_ack_i = 0; wb_dat_i = '0;
    chk("col done0", 32'(req0_done), 32'd1);
    chk("col err0", 32'(req0_err), 32'd0);
    chk("col rdata", rdata, 32'hCAFE_F00D);
    req0_valid = 0;
    @(negedge clk);

    // Reset mid-BUS, then requester 0 wins a tie
    req0_valid = 1; req0_we = 1; req0_adr = 32'h3000_0600; req0_wdat = 32'h7777_0000;
    @(negedge clk);
    chk("mr cyc", 32'(wb_cyc_o), 32'd1);
    nRst = 0;
    @(negedge clk);
    chk_idle("mr rst");
    chk("mr adr", wb_adr_o, 32'd0);
    chk("mr dat", wb_dat_o, 32'd0);
    chk("mr we", 32'(wb_we_o), 32'd0);
    chk("mr sel", 32'(wb_sel_o), 32'd0);
    chk("mr rdata", rdata, 32'd0);
    nRst = 1;
    req0_we = 0;
    req1_valid = 1; req1_we = 0; req1_adr = 32'h3000_0700;
    @(negedge clk);
    chk("mr tie cyc", 32'(wb_cyc_o), 32'd1);
    chk("mr tie adr", wb_adr_o, 32'h3000_0600);
    wb_ack_i = 1; wb_dat_i = 32'h0BAD_CAFE;
    @(negedge clk);
    wb_ack_i = 0; wb_dat_i = '0;
    chk("mr done0", 32'(req0_done), 32'd1);
    chk("mr done1", 32'(req1_done), 32'd0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk_idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
